score_display: RTL and testbench
================================

# score_display

Display back end for the game: takes the live `timealive` score and `lives` count from the game core and drives a 4-digit, common-anode, multiplexed seven-segment display. The block converts binary to BCD with a sequential shift-add-3 converter, latches the result into a display register and time-multiplexes the four digits with a refresh counter. It sits directly downstream of the game core and directly upstream of the board pins.

## Interface
Parameters:
- `REFRESH_BITS`, default 17: width of the refresh counter. Digit select is its top 2 bits. Benches use 4.

Ports:
- `clb`  in  1: system clock. All state is clocked on its rising edge.
- `clr`  in  1: asynchronous, active-high reset.
- `timealive`  in  16: binary score from the game core.
- `lives`  in  2: remaining lives, 0–3.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  4: digit anodes, active-low. `an[0]` is the rightmost (ones) digit.
- `dp`  out  1: decimal point, active-low.
- `busy`  out  1: high while a conversion is in progress.

## Operation
- FSM states: IDLE, SHIFT, LOAD.
- **IDLE:** if `timealive != last_val`:
  - capture `src = (timealive > 9999) ? 9999 : timealive`;
  - set `last_val <= timealive` (the raw, unsaturated value);
  - clear the BCD accumulator; `cnt <= 0`; go to SHIFT.
- **SHIFT:** one bit per cycle, 16 cycles.
  - Each 4-bit BCD nibble that is ≥5 gets +3.
  - Then shift `{bcd, src}` left by 1.
  - `cnt` increments; after the 16th shift, go to LOAD.
- **LOAD:** copy the 4 BCD nibbles into `disp[15:0]`; go to IDLE.
- `busy` is high in SHIFT and LOAD.
- An input change during a conversion is not aborted. IDLE re-evaluates the new value on the next cycle, so the latest value is always displayed eventually.
- Refresh counter: free-running, `REFRESH_BITS` wide, wraps to 0.
  - Top 2 bits `sel` select the digit: 0 = ones ... 3 = thousands.
  - `an = ~(4'b0001 << sel)`.
  - `seg = decode(disp nibble sel)`.
- Decode, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any other nibble = 1111111 (blank).
- No leading-zero blanking.
- `seg`, `an` and `dp` are registered.

## Timing
- Reset values:
  - FSM = IDLE, `busy = 0`, `disp = 0`, `last_val = 0`, refresh counter = 0.
  - `an = 4'b1110`, `seg = 7'b1000000` ("0"), `dp = 1`.
- Latency: `timealive` change sampled at edge N (IDLE → SHIFT) → SHIFT edges N+1..N+16 → LOAD at N+17 → `disp` valid after edge N+17. Visible on `seg` one edge later, when that digit is selected.
- `busy` rises after edge N and falls after edge N+17.
- `clr` mid-conversion: FSM returns to IDLE immediately, `disp` = 0.
  - `last_val` = 0 after reset, so a nonzero `timealive` starts a fresh conversion on the first edge after release.
- Saturation boundary: 9999 displays 9999; 10000 and 65535 display 9999.
- Digit dwell: `2^(REFRESH_BITS-2)` cycles per digit. Full scan period: `2^REFRESH_BITS` cycles.

## Configuration
- Macro `SCORE_DISPLAY_LIVES_DP_EN`:
  - **Defined:** `dp = 0` (lit) when `sel < lives`. lives = 2 lights the DP on digits 0 and 1; lives = 0 lights none. `dp` tracks `lives` combinationally through the `dp` output register, with no conversion latency.
  - **Undefined:** `dp` is held at 1 (off); `lives` is unused.

## Test plan
- Reset, then `timealive = 1234`: `busy` high for exactly 17 cycles; `disp = 16'h1234`; when `an = 1110`, `seg = 0011001` ("4"); when `an = 0111`, `seg = 1111001` ("1").
- `timealive = 12345`, then `65535`: `disp = 16'h9999` both times; `timealive = 9999` → `16'h9999`; `timealive = 0` after a nonzero value → `16'h0000`.
- Change `timealive` from 10 to 20 four cycles into a conversion: first `disp = 16'h0010`, then a second conversion gives `16'h0020` within 36 cycles of the first change.
- Assert `clr` at cycle 8 of the SHIFT state for `timealive = 4321`: outputs go to reset values immediately; after release, `disp = 16'h4321` 18 cycles later.
- `REFRESH_BITS = 4`: `an` steps 1110 → 1101 → 1011 → 0111, 4 cycles each, wrapping back to 1110 on cycle 16.
- With `SCORE_DISPLAY_LIVES_DP_EN`, `lives = 2`: `dp = 0` only while `an` is 1110 or 1101; with `lives = 0`, `dp` stays 1. Without the macro, `dp` stays 1 for any `lives`.

Source files
------------

// File: rtl/score_display.sv
// Score display back end: sequential shift-add-3 binary-to-BCD conversion feeding a 4-digit multiplexed seven-segment driver.
// Optional macro SCORE_DISPLAY_LIVES_DP_EN lights the decimal point on the lowest `lives` digits.
module score_display #(
   parameter int REFRESH_BITS = 17
) (
   input  logic        clb,
   input  logic        clr,
   input  logic [15:0] timealive,
   input  logic [1:0]  lives,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

   state_t                  state_q, state_d;
   logic [15:0]             src_q, src_d;
   logic [15:0]             bcd_q, bcd_d;
   logic [15:0]             disp_q, disp_d;
   logic [15:0]             last_val_q, last_val_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [REFRESH_BITS-1:0] ref_q, ref_d;
   logic [6:0]              seg_q, seg_d;
   logic [3:0]              an_q, an_d;
   logic                    dp_q, dp_d;
   logic [15:0]             bcd_adj;
   logic [1:0]              sel_d;
   logic [3:0]              nib;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'b1111111;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      disp_d     = disp_q;
      last_val_d = last_val_q;
      bcd_adj    = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
         end
      end
      case (state_q)
         IDLE: begin
            // last_val keeps the raw value so a change between two saturated values still reconverts
            if (timealive != last_val_q) begin
               src_d      = (timealive > 16'd9999) ? 16'd9999 : timealive;
               last_val_d = timealive;
               bcd_d      = '0;
               cnt_d      = '0;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, src_d} = {bcd_adj[14:0], src_q, 1'b0};
            cnt_d          = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            disp_d  = bcd_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ref_d = ref_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      // Outputs are decoded from the next counter value so an/seg/dp line up with the counter itself
      sel_d = ref_d[REFRESH_BITS-1 -: 2];
      nib   = disp_q[3:0];
      case (sel_d)
         2'd0:    nib = disp_q[3:0];
         2'd1:    nib = disp_q[7:4];
         2'd2:    nib = disp_q[11:8];
         default: nib = disp_q[15:12];
      endcase
      seg_d = decode(nib);
      an_d  = ~(4'b0001 << sel_d);
`ifdef SCORE_DISPLAY_LIVES_DP_EN
      dp_d  = (sel_d >= lives);
`else
      dp_d  = 1'b1;
`endif
   end

`ifndef SCORE_DISPLAY_LIVES_DP_EN
   logic unused_lives;
   assign unused_lives = ^lives;
`endif

   always_ff @(posedge clb or posedge clr) begin
      if (clr) begin
         state_q    <= IDLE;
         src_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         disp_q     <= '0;
         last_val_q <= '0;
         ref_q      <= '0;
         seg_q      <= 7'b1000000;
         an_q       <= 4'b1110;
         dp_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         disp_q     <= disp_d;
         last_val_q <= last_val_d;
         ref_q      <= ref_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
         dp_q       <= dp_d;
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign dp   = dp_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: event-time model of conversions and digit scanning, checked every cycle, plus literal spot checks.
module tb_score_display;
   localparam int RB = 4;

   logic        clb = 1'b0;
   logic        clr = 1'b1;
   logic [15:0] timealive = 16'd0;
   logic [1:0]  lives = 2'd0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic        busy;

   score_display #(.REFRESH_BITS(RB)) dut (
      .clb(clb), .clr(clr), .timealive(timealive), .lives(lives),
      .seg(seg), .an(an), .dp(dp), .busy(busy)
   );

   always #5 clb = ~clb;

   int n_vec = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   int pw [0:3] = '{1, 10, 100, 1000};

   // Model: edge index since reset, value shown, and the edge window of the conversion in flight
   int m_k = 0, m_last = 0, m_disp = 0, m_prev = 0, m_pend = 0;
   int m_start = -100, m_end = -100, m_lives = 0;

   always @(posedge clb or posedge clr) begin
      if (clr) begin
         m_k = 0; m_last = 0; m_disp = 0; m_prev = 0;
         m_start = -100; m_end = -100; m_lives = 0;
      end else begin
         m_k++;
         m_prev  = m_disp;
         m_lives = int'(lives);
         if (m_k > m_end && int'(timealive) != m_last) begin
            m_last  = int'(timealive);
            m_pend  = (m_last > 9999) ? 9999 : m_last;
            m_start = m_k;
            m_end   = m_k + 17;
         end
         if (m_k == m_end) m_disp = m_pend;
      end
   end

   always @(negedge clb) begin
      if (chk_en) begin
         int sel, dig, dp_e;
         logic [3:0] an_e;
         sel  = (m_k % (1 << RB)) / (1 << (RB - 2));
         dig  = (m_prev / pw[sel]) % 10;
         an_e = ~(4'b0001 << sel);
`ifdef SCORE_DISPLAY_LIVES_DP_EN
         dp_e = (m_k == 0) ? 1 : ((sel < m_lives) ? 0 : 1);
`else
         dp_e = 1;
`endif
         check("an", int'(an), int'(an_e));
         check("seg", int'(seg), int'(segtab[dig]));
         check("dp", int'(dp), dp_e);
         check("busy", int'(busy), (m_k >= m_start && m_k < m_end) ? 1 : 0);
      end
   end

   logic [6:0] sg [4];
   logic       dpv [4];
   int         dw [4];

   task automatic scan();
      for (int i = 0; i < 4; i++) dw[i] = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clb);
         for (int i = 0; i < 4; i++) begin
            if (an == ~(4'b0001 << i)) begin
               sg[i]  = seg;
               dpv[i] = dp;
               dw[i]++;
            end
         end
      end
   endtask

   task automatic chk_digits(input string nm, input int d3, input int d2, input int d1, input int d0);
      int d [4];
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      scan();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s digit%0d", nm, i), int'(sg[i]), int'(segtab[d[i]]));
         check($sformatf("%s dwell%0d", nm, i), dw[i], 4);
      end
   endtask

   task automatic set_val(input int v, input int wait_cyc);
      @(negedge clb);
      timealive = 16'(v);
      repeat (wait_cyc) @(negedge clb);
   endtask

   initial begin
      int nb, t;
      repeat (2) @(negedge clb);
      chk_en = 1'b1;
      #1;
      check("rst seg", int'(seg), 7'b1000000);
      check("rst an", int'(an), 4'b1110);
      check("rst dp", int'(dp), 1);
      check("rst busy", int'(busy), 0);
      #1 clr = 1'b0;

      // 1234: busy length and literal digit patterns
      @(negedge clb);
      timealive = 16'd1234;
      nb = 0;
      repeat (30) begin
         @(negedge clb);
         if (busy) nb++;
      end
      check("busy len", nb, 17);
      check("model 1234", m_disp, 1234);
      scan();
      check("1234 ones", int'(sg[0]), 7'b0011001);
      check("1234 tens", int'(sg[1]), 7'b0110000);
      check("1234 hund", int'(sg[2]), 7'b0100100);
      check("1234 thou", int'(sg[3]), 7'b1111001);

      // Saturation boundaries and return to zero
      set_val(12345, 20);
      check("model 12345", m_disp, 9999);
      chk_digits("12345", 9, 9, 9, 9);
      set_val(65535, 20);
      chk_digits("65535", 9, 9, 9, 9);
      set_val(9999, 20);
      chk_digits("9999", 9, 9, 9, 9);
      set_val(0, 20);
      check("model zero", m_disp, 0);
      chk_digits("zero", 0, 0, 0, 0);

      // Change during a conversion is picked up by a second conversion
      set_val(10, 4);
      timealive = 16'd20;
      repeat (32) @(negedge clb);
      check("model 20", m_disp, 20);
      chk_digits("10to20", 0, 0, 2, 0);

      // Reset in the middle of SHIFT, then a fresh conversion after release
      @(negedge clb);
      timealive = 16'd4321;
      t = 0;
      while (!busy && t < 5) begin
         @(negedge clb);
         t++;
      end
      check("busy rise", int'(busy), 1);
      repeat (7) @(posedge clb);
      #2 clr = 1'b1;
      #1;
      check("clr seg", int'(seg), 7'b1000000);
      check("clr an", int'(an), 4'b1110);
      check("clr busy", int'(busy), 0);
      check("clr dp", int'(dp), 1);
      @(negedge clb);
      #2 clr = 1'b0;
      repeat (18) @(posedge clb);
      #1 check("model 4321", m_disp, 4321);
      repeat (3) @(negedge clb);
      chk_digits("4321", 4, 3, 2, 1);

      // Decimal points as a lives indicator
      lives = 2'd2;
      repeat (2) @(negedge clb);
      scan();
      for (int i = 0; i < 4; i++) begin
`ifdef SCORE_DISPLAY_LIVES_DP_EN
         check($sformatf("dp lives2 digit%0d", i), int'(dpv[i]), (i < 2) ? 0 : 1);
`else
         check($sformatf("dp lives2 digit%0d", i), int'(dpv[i]), 1);
`endif
      end
      lives = 2'd0;
      repeat (2) @(negedge clb);
      scan();
      for (int i = 0; i < 4; i++) check($sformatf("dp lives0 digit%0d", i), int'(dpv[i]), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
